// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with a two-state line-refill controller.
// Optional hit/miss performance counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_ctrl #(
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 pc,
  input  logic                        invalidate,
  output logic [31:0]                 instruction,
  output logic                        block_pipe_instr_cache,
  output logic                        mem_req,
  output logic [31:0]                 mem_addr,
  input  logic                        mem_ready,
  input  logic [32*WORDS_PER_LINE-1:0] mem_rdata,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
);

  localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int LINE_OFF  = 2 + WORD_BITS;
  localparam int TAG_W     = 32 - LINE_OFF - IDX_BITS;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MISS = 1'b1;

  logic [0:0]                              state;
  logic [NUM_LINES-1:0]                    valid;
  logic [TAG_W-1:0]                        tag_mem  [NUM_LINES];
  logic [WORDS_PER_LINE-1:0][31:0]         data_mem [NUM_LINES];

  logic [WORD_BITS-1:0] pc_word;
  logic [IDX_BITS-1:0]  pc_idx;
  logic [TAG_W-1:0]     pc_tag;
  logic [IDX_BITS-1:0]  fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic                 hit;
  logic                 fill_done;
  logic [1:0]           unused_pc_offset;

  assign unused_pc_offset = pc[1:0];

  assign pc_word = pc[2 +: WORD_BITS];
  assign pc_idx  = pc[LINE_OFF +: IDX_BITS];
  assign pc_tag  = pc[31 -: TAG_W];

  // The refill target is taken from the latched line address, never from the live pc.
  assign fill_idx  = mem_addr[LINE_OFF +: IDX_BITS];
  assign fill_tag  = mem_addr[31 -: TAG_W];
  assign fill_done = (state == ST_MISS) && mem_ready;

  // Lookup stage: combinational tag compare against the current pc
  always_comb begin
    hit         = 1'b0;
    instruction = 32'h0000_0000;
    if ((state == ST_IDLE) && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag)) begin
      hit         = 1'b1;
      instruction = data_mem[pc_idx][pc_word];
    end
  end

  assign block_pipe_instr_cache = ~hit;

  // Controller stage: FSM, valid bits and the registered refill request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      valid    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0000_0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!hit) begin
            state    <= ST_MISS;
            mem_req  <= 1'b1;
            mem_addr <= {pc[31:LINE_OFF], {LINE_OFF{1'b0}}};
          end
        end
        ST_MISS: begin
          if (mem_ready) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase

      // Invalidate wins over a refill finishing in the same cycle.
      if (invalidate) begin
        valid <= '0;
      end else if (fill_done) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Storage stage: tags and line data carry no reset
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_rdata;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= 32'h0000_0000;
      miss_cnt_q <= 32'h0000_0000;
    end else begin
      if (hit) begin
        hit_cnt_q <= hit_cnt_q + 32'h0000_0001;
      end
      if ((state == ST_IDLE) && !hit) begin
        miss_cnt_q <= miss_cnt_q + 32'h0000_0001;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'h0000_0000;
  assign miss_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: miss/refill, hits, eviction, pc change
// mid-refill, invalidate collision and asynchronous reset mid-refill.
module tb_icache_ctrl;

  logic         clk;
  logic         reset;
  logic [31:0]  pc;
  logic         invalidate;
  logic [31:0]  instruction;
  logic         block_pipe_instr_cache;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int checks   = 0;
  int failures = 0;

`ifdef ICACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [127:0] LINE_D = {32'hD333_0003, 32'hD222_0002, 32'hD111_0001, 32'hD000_0000};
  localparam logic [127:0] LINE_E = {32'hE333_0003, 32'hE222_0002, 32'hE111_0001, 32'hE000_0000};
  localparam logic [127:0] LINE_F = {32'hF333_0003, 32'hF222_0002, 32'hF111_0001, 32'hF000_0000};
  localparam logic [127:0] LINE_G = {32'hA333_0003, 32'hA222_0002, 32'hA111_0001, 32'hA000_0000};
  localparam logic [127:0] LINE_H = {32'hB333_0003, 32'hB222_0002, 32'hB111_0001, 32'hB000_0000};
  localparam logic [127:0] LINE_X = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};

  icache_ctrl #(
    .NUM_LINES      (4),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .pc                     (pc),
    .invalidate             (invalidate),
    .instruction            (instruction),
    .block_pipe_instr_cache (block_pipe_instr_cache),
    .mem_req                (mem_req),
    .mem_addr               (mem_addr),
    .mem_ready              (mem_ready),
    .mem_rdata              (mem_rdata),
    .hit_count              (hit_count),
    .miss_count             (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    pc         = 32'h0000_0040;
    invalidate = 1'b0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    #2;
    chk("rst_block",    {31'd0, block_pipe_instr_cache}, 32'd1);
    chk("rst_mem_req",  {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0000_0000);
    chk("rst_hit_cnt",  hit_count, 32'd0);
    chk("rst_miss_cnt", miss_count, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;

    // Cold miss on 0x40
    chk("cold_block_c0", {31'd0, block_pipe_instr_cache}, 32'd1);
    chk("cold_instr_c0", instruction, 32'h0000_0000);
    chk("cold_req_c0",   {31'd0, mem_req}, 32'd0);
    tick();
    chk("cold_req",      {31'd0, mem_req}, 32'd1);
    chk("cold_addr",     mem_addr, 32'h0000_0040);
    chk("cold_block_m",  {31'd0, block_pipe_instr_cache}, 32'd1);
    tick();
    tick();
    chk("cold_req_hold", {31'd0, mem_req}, 32'd1);
    chk("cold_instr_m",  instruction, 32'h0000_0000);
    mem_ready = 1'b1;
    mem_rdata = LINE_D;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    chk("cold_block_done", {31'd0, block_pipe_instr_cache}, 32'd0);
    chk("cold_instr_d0",   instruction, 32'hD000_0000);
    chk("cold_req_drop",   {31'd0, mem_req}, 32'd0);

    // Hit within the same line
    pc = 32'h0000_0048;
    #1;
    chk("hit_instr_d2", instruction, 32'hD222_0002);
    chk("hit_block",    {31'd0, block_pipe_instr_cache}, 32'd0);
    tick();
    chk("hit_no_req",   {31'd0, mem_req}, 32'd0);
    chk("hit_cnt_1",    hit_count, PERF ? 32'd1 : 32'd0);
    chk("miss_cnt_1",   miss_count, PERF ? 32'd1 : 32'd0);

    // mem_ready while IDLE must not disturb the cache
    mem_ready = 1'b1;
    mem_rdata = LINE_X;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("idle_ready_instr", instruction, 32'hD222_0002);
    chk("idle_ready_req",   {31'd0, mem_req}, 32'd0);

    // Conflict eviction: 0x80 shares index 0 with 0x40
    pc = 32'h0000_0080;
    #1;
    chk("evict_block", {31'd0, block_pipe_instr_cache}, 32'd1);
    tick();
    chk("evict_addr", mem_addr, 32'h0000_0080);
    mem_ready = 1'b1;
    mem_rdata = LINE_E;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("evict_instr_e0", instruction, 32'hE000_0000);
    pc = 32'h0000_0040;
    #1;
    chk("evict_remiss", {31'd0, block_pipe_instr_cache}, 32'd1);
    tick();
    chk("evict_addr2",  mem_addr, 32'h0000_0040);
    chk("evict_miss_cnt", miss_count, PERF ? 32'd3 : 32'd0);
    mem_ready = 1'b1;
    mem_rdata = LINE_D;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("evict_refill_d0", instruction, 32'hD000_0000);

    // pc change during MISS does not redirect the refill
    pc = 32'h0000_0010;
    tick();
    chk("pcchg_addr", mem_addr, 32'h0000_0010);
    pc = 32'h0000_0020;
    tick();
    chk("pcchg_addr_stable", mem_addr, 32'h0000_0010);
    chk("pcchg_block", {31'd0, block_pipe_instr_cache}, 32'd1);
    mem_ready = 1'b1;
    mem_rdata = LINE_F;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("pcchg_idle_block", {31'd0, block_pipe_instr_cache}, 32'd1);
    chk("pcchg_idle_req",   {31'd0, mem_req}, 32'd0);
    tick();
    chk("pcchg_req2",  {31'd0, mem_req}, 32'd1);
    chk("pcchg_addr2", mem_addr, 32'h0000_0020);
    mem_ready = 1'b1;
    mem_rdata = LINE_G;
    tick();
    mem_ready = 1'b0;
    pc = 32'h0000_0024;
    #1;
    chk("pcchg_g1", instruction, 32'hA111_0001);
    pc = 32'h0000_001C;
    #1;
    chk("pcchg_f3", instruction, 32'hF333_0003);

    // Invalidate in the same cycle as the refill strobe
    pc = 32'h0000_0030;
    tick();
    chk("inv_addr", mem_addr, 32'h0000_0030);
    mem_ready  = 1'b1;
    invalidate = 1'b1;
    mem_rdata  = LINE_H;
    tick();
    mem_ready  = 1'b0;
    invalidate = 1'b0;
    #1;
    chk("inv_block", {31'd0, block_pipe_instr_cache}, 32'd1);
    chk("inv_instr", instruction, 32'h0000_0000);
    tick();
    chk("inv_req", {31'd0, mem_req}, 32'd1);
    chk("inv_addr2", mem_addr, 32'h0000_0030);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("inv_refill_h0", instruction, 32'hB000_0000);
    pc = 32'h0000_0010;
    #1;
    chk("inv_other_cleared", {31'd0, block_pipe_instr_cache}, 32'd1);

    // Asynchronous reset during a refill
    pc = 32'h0000_0030;
    #1;
    chk("rstm_hit_before", {31'd0, block_pipe_instr_cache}, 32'd0);
    pc = 32'h0000_0040;
    tick();
    chk("rstm_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rstm_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rstm_addr",     mem_addr, 32'h0000_0000);
    chk("rstm_miss_cnt", miss_count, 32'd0);
    chk("rstm_hit_cnt",  hit_count, 32'd0);
    tick();
    reset = 1'b1;
    pc    = 32'h0000_0030;
    #1;
    chk("rstm_refilled_miss", {31'd0, block_pipe_instr_cache}, 32'd1);
    tick();
    chk("rstm_new_req",  {31'd0, mem_req}, 32'd1);
    chk("rstm_new_addr", mem_addr, 32'h0000_0030);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
